// File: rtl/mux16_pkg.sv
// Shared types and constants for the 16:1 mux scan sequencer.
package mux16_pkg;

    localparam int unsigned MUX_N = 16;
    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_ZERO = 4'h0;
    localparam logic [SEL_W-1:0] SEL_ONE  = 4'h1;
    localparam logic [SEL_W-1:0] SEL_MAX  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index the scan begins at for the given direction.
    function automatic logic [SEL_W-1:0] first_sel(input logic dir);
        if (dir) begin
            return SEL_MAX;
        end else begin
            return SEL_ZERO;
        end
    endfunction

    // Index the scan ends at for the given direction.
    function automatic logic [SEL_W-1:0] last_sel(input logic dir);
        if (dir) begin
            return SEL_ZERO;
        end else begin
            return SEL_MAX;
        end
    endfunction

endpackage

// File: rtl/mux16_sel_counter.sv
// Up/down select counter: loads the first scan index, steps toward the last one.
module mux16_sel_counter
    import mux16_pkg::*;
#(
    parameter bit DIR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] sel,
    output logic             at_last
);

    logic [SEL_W-1:0] sel_r;

    // Select register; load has priority so a scan can always restart cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= SEL_ZERO;
        end else if (load) begin
            sel_r <= first_sel(DIR);
        end else if (en) begin
            if (DIR) begin
                sel_r <= sel_r - SEL_ONE;
            end else begin
                sel_r <= sel_r + SEL_ONE;
            end
        end else begin
            sel_r <= sel_r;
        end
    end

    assign sel     = sel_r;
    assign at_last = (sel_r == last_sel(DIR));

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Walks a 16:1 mux select through all positions and reassembles the
// serial mux output into a 16-bit word with a one-cycle done pulse.
module mux16_scan_ctrl
    import mux16_pkg::*;
#(
    parameter bit DIR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mux_o,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [MUX_N-1:0] data_out
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic [MUX_N-1:0] data_r;
    logic [MUX_N-1:0] data_nxt_s;
    logic [MUX_N-1:0] shadow_r;
    logic [MUX_N-1:0] shadow_nxt_s;
    logic             cnt_load_s;
    logic             cnt_en_s;
    logic [SEL_W-1:0] sel_s;
    logic             at_last_s;

    mux16_sel_counter #(
        .DIR (DIR)
    ) u_sel_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load_s),
        .en      (cnt_en_s),
        .sel     (sel_s),
        .at_last (at_last_s)
    );

    // State, flags, shadow and captured word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            data_r   <= 16'h0000;
            shadow_r <= 16'h0000;
        end else begin
            state_r  <= state_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            data_r   <= data_nxt_s;
            shadow_r <= shadow_nxt_s;
        end
    end

    // Next-state and next-output logic. mux_o feeds the shadow/data D inputs
    // directly so the last bit lands in data_out on the same edge it is sampled.
    always_comb begin
        state_nxt_s  = state_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        data_nxt_s   = data_r;
        shadow_nxt_s = shadow_r;
        cnt_load_s   = 1'b0;
        cnt_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_load_s = 1'b1;
                if (start) begin
                    state_nxt_s = ST_SCAN;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    cnt_load_s  = 1'b1;
                end else begin
                    shadow_nxt_s[sel_s] = mux_o;
                    if (at_last_s) begin
                        data_nxt_s  = shadow_nxt_s;
                        done_nxt_s  = 1'b1;
                        busy_nxt_s  = 1'b0;
                        state_nxt_s = ST_DONE;
                        cnt_load_s  = 1'b1;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_load_s  = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
                cnt_load_s  = 1'b1;
            end
        endcase
    end

    assign sel      = sel_s;
    assign busy     = busy_r;
    assign done     = done_r;
    assign data_out = data_r;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Self-checking bench: ascending and descending instances run in lockstep,
// each fed by its own behavioural 16:1 mux.
module tb_mux16_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] word0 = 16'h0000;
    logic [15:0] word1 = 16'h0000;
    logic        mux_o0, mux_o1;
    logic [3:0]  sel0, sel1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] data_out0, data_out1;
    int          n_pass = 0;
    int          n_total = 0;
    int          edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    assign mux_o0 = word0[sel0];
    assign mux_o1 = word1[sel1];

    mux16_scan_ctrl #(.DIR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mux_o(mux_o0),
        .sel(sel0), .busy(busy0), .done(done0), .data_out(data_out0)
    );

    mux16_scan_ctrl #(.DIR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mux_o(mux_o1),
        .sel(sel1), .busy(busy1), .done(done1), .data_out(data_out1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full scan of both instances; captured word must equal the static mux word.
    task automatic run_scan(input logic [15:0] w0, input logic [15:0] w1,
                            input bit mid_start, input bit abort_at_start);
        logic [3:0] e0, e1;
        word0 = w0;
        word1 = w1;
        start = 1'b1;
        abort = abort_at_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e0 = 4'(i);
            e1 = 4'(15 - i);
            n_total++;
            if (sel0 !== e0 || sel1 !== e1)
                $display("FAIL scan_sel step %0d: got %0d/%0d want %0d/%0d", i, sel0, sel1, e0, e1);
            else n_pass++;
            n_total++;
            if (busy0 !== 1'b1 || busy1 !== 1'b1 || done0 !== 1'b0 || done1 !== 1'b0)
                $display("FAIL scan_flags step %0d: busy %b/%b done %b/%b want 1/1 0/0", i, busy0, busy1, done0, done1);
            else n_pass++;
            start = (mid_start && i == 5) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        n_total++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || busy0 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL scan_done: done %b/%b busy %b/%b want 1/1 0/0", done0, done1, busy0, busy1);
        else n_pass++;
        n_total++;
        if (data_out0 !== w0 || data_out1 !== w1)
            $display("FAIL scan_data: got %h/%h want %h/%h", data_out0, data_out1, w0, w1);
        else n_pass++;
        n_total++;
        if (sel0 !== 4'd0 || sel1 !== 4'd15)
            $display("FAIL scan_sel_reload: got %0d/%0d want 0/15", sel0, sel1);
        else n_pass++;
        tick();
        n_total++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || data_out0 !== w0 || data_out1 !== w1)
            $display("FAIL done_pulse: done %b/%b data %h/%h want 0/0 %h/%h", done0, done1, data_out0, data_out1, w0, w1);
        else n_pass++;
        tick();
        n_total++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL no_queued_start: busy %b/%b want 0/0", busy0, busy1);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        n_total++;
        if (sel0 !== 4'd0 || sel1 !== 4'd0 || busy0 !== 1'b0 || busy1 !== 1'b0 ||
            done0 !== 1'b0 || done1 !== 1'b0 || data_out0 !== 16'h0000 || data_out1 !== 16'h0000)
            $display("FAIL reset_state: sel %0d/%0d busy %b/%b done %b/%b data %h/%h want all zero",
                     sel0, sel1, busy0, busy1, done0, done1, data_out0, data_out1);
        else n_pass++;
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (sel0 !== 4'd0 || sel1 !== 4'd15 || busy0 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL idle_sel: sel %0d/%0d busy %b/%b want 0/15 0/0", sel0, sel1, busy0, busy1);
        else n_pass++;
    endtask

    task automatic test_scan_fixed();
        run_scan(16'hA5C3, 16'h8001, 1'b0, 1'b0);
    endtask

    task automatic test_scan_random();
        for (int k = 0; k < 4; k++)
            run_scan(16'($urandom), 16'($urandom), (k == 1), (k == 2));
    endtask

    task automatic test_abort();
        run_scan(16'h1234, 16'h1234, 1'b0, 1'b0);
        word0 = 16'hFFFF;
        word1 = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || sel0 !== 4'd0 || sel1 !== 4'd15)
            $display("FAIL abort_mid: busy %b/%b sel %0d/%0d want 0/0 0/15", busy0, busy1, sel0, sel1);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_total++;
            if (done0 !== 1'b0 || done1 !== 1'b0 || data_out0 !== 16'h1234 || data_out1 !== 16'h1234)
                $display("FAIL abort_hold cycle %0d: done %b/%b data %h/%h want 0/0 1234/1234",
                         i, done0, done1, data_out0, data_out1);
            else n_pass++;
            tick();
        end
        // Abort landing on the last-index edge wins over completion.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 ||
                data_out0 !== 16'h1234 || data_out1 !== 16'h1234)
                $display("FAIL abort_last cycle %0d: done %b/%b busy %b data %h/%h want 0/0 0 1234/1234",
                         i, done0, done1, busy0, data_out0, data_out1);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp0, exp1, tmp;
        int s, prev;
        bit got;
        exp0 = 16'h0F0F;
        exp1 = 16'hF0F0;
        word0 = exp0;
        word1 = exp1;
        s = edge_cnt;
        prev = 0;
        start = 1'b1;
        for (int f = 0; f < 4; f++) begin
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                tick();
                if (done0 === 1'b1) got = 1'b1;
            end
            n_total++;
            if (!got) $display("FAIL b2b_timeout frame %0d: done 0 want 1", f);
            else n_pass++;
            n_total++;
            if (data_out0 !== exp0 || data_out1 !== exp1 || done1 !== 1'b1)
                $display("FAIL b2b_data frame %0d: got %h/%h done1 %b want %h/%h 1",
                         f, data_out0, data_out1, done1, exp0, exp1);
            else n_pass++;
            n_total++;
            if ((f == 0 && edge_cnt - s != 17) || (f > 0 && edge_cnt - prev != 18))
                $display("FAIL b2b_spacing frame %0d: edge %0d prev %0d start %0d want 17 from start / 18 apart",
                         f, edge_cnt, prev, s);
            else n_pass++;
            prev = edge_cnt;
            tmp = exp0;
            exp0 = exp1;
            exp1 = tmp;
            word0 = exp0;
            word1 = exp1;
        end
        start = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_scan();
        word0 = 16'hBEEF;
        word1 = 16'hBEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (data_out0 !== 16'h0000 || data_out1 !== 16'h0000 || busy0 !== 1'b0 ||
            done0 !== 1'b0 || sel0 !== 4'd0 || sel1 !== 4'd0)
            $display("FAIL reset_mid: data %h/%h busy %b done %b sel %0d/%0d want 0000/0000 0 0 0/0",
                     data_out0, data_out1, busy0, done0, sel0, sel1);
        else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_total++;
            if (done0 !== 1'b0 || done1 !== 1'b0 || data_out0 !== 16'h0000)
                $display("FAIL reset_no_done cycle %0d: done %b/%b data %h want 0/0 0000", i, done0, done1, data_out0);
            else n_pass++;
        end
        run_scan(16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_scan_fixed();
        test_scan_random();
        test_abort();
        test_back_to_back();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
